// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Groups the pipeline-side signals of the hazard controller.
//   master : pipeline / testbench side (drives stage fields, sees controls)
//   slave  : hazard_ctrl (reads stage fields, drives stall/flush/forward,
//            error flag and performance counters)
interface hazard_ctrl_if;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;
    logic [4:0]  rdM;
    logic [4:0]  rdW;
    logic        regwriteE;
    logic        regwriteM;
    logic        regwriteW;
    logic [1:0]  wbselE;
    logic        pcselE;
    logic        dmem_reqM;
    logic        dmem_ready;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        stallM;
    logic        flushD;
    logic        flushE;
    logic        flushW;
    logic [1:0]  fwdAE;
    logic [1:0]  fwdBE;
    logic        mem_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output regwriteE, regwriteM, regwriteW, wbselE, pcselE,
        output dmem_reqM, dmem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        input  fwdAE, fwdBE, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  regwriteE, regwriteM, regwriteW, wbselE, pcselE,
        input  dmem_reqM, dmem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
        output fwdAE, fwdBE, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard, stall and flush controller for the 5-stage RV32 pipeline.
//   Forwarding selects, load-use stalls and redirect flushes are purely
//   combinational; a small FSM freezes the pipeline while a data-memory
//   access is not ready and latches a sticky error on timeout.
// Ports
//   clk   : pipeline clock, rising edge
//   rst_n : asynchronous active-low reset
//   hz    : hazard_ctrl_if.slave (stage fields in, stall/flush/forward,
//           mem_err and stall/flush performance counters out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// RUN    | normal flow, no outstanding memory wait
// WAIT   | memory access in Memory not ready, pipeline frozen
// ERR    | memory wait exceeded MEM_TIMEOUT, frozen until reset
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mem_stall;
    logic in_err;
    logic redirect;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    // Most recent producer wins: M has priority over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (hz.regwriteM && (hz.rdM != 5'd0) && (hz.rdM == rs)) begin
            return 2'b10;
        end else if (hz.regwriteW && (hz.rdW != 5'd0) && (hz.rdW == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    assign hz.fwdAE = fwd_sel(hz.rs1E);
    assign hz.fwdBE = fwd_sel(hz.rs2E);

    // rs2D is compared even when the Decode instruction has no rs2.
    assign load_use = hz.regwriteE && (hz.wbselE == 2'b00) && (hz.rdE != 5'd0) &&
                      ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

    assign in_err    = (state_q == ST_ERR);
    assign mem_stall = hz.dmem_reqM && !hz.dmem_ready && !in_err;

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_w  = 1'b0;
        redirect = 1'b0;
        if (in_err || mem_stall) begin
            // Frozen pipeline: redirect and load-use are deferred.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.pcselE) begin
            flush_d  = 1'b1;
            flush_e  = 1'b1;
            redirect = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            ST_WAIT: begin
                if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 16'd0;
            end
        endcase
    end

    assign stall_cnt_d = stall_f  ? stall_cnt_q + 32'd1 : stall_cnt_q;
    assign flush_cnt_d = redirect ? flush_cnt_q + 32'd1 : flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stallF    = stall_f;
    assign hz.stallD    = stall_d;
    assign hz.stallE    = stall_e;
    assign hz.stallM    = stall_m;
    assign hz.flushD    = flush_d;
    assign hz.flushE    = flush_e;
    assign hz.flushW    = flush_w;
    assign hz.mem_err   = in_err;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       rwE, rwM, rwW;
        logic [1:0] wbsel;
        logic       pcsel, req, rdy;
        logic [1:0] fa, fb;
        logic [3:0] stall;   // {F,D,E,M}
        logic [2:0] flush;   // {D,E,W}
    } vec_t;

    typedef struct {
        string       name;
        logic [1:0]  fa, fb;
        logic [3:0]  stall;
        logic [2:0]  flush;
        logic        err;
        logic [31:0] sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] sc_m = 32'd0;
    logic [31:0] fc_m = 32'd0;

    hazard_ctrl_if hz ();

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input string name,
                                 input logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
                                 input logic rwE, rwM, rwW, input logic [1:0] wbsel,
                                 input logic pcsel, req, rdy,
                                 input logic [1:0] fa, fb, input logic [3:0] stall,
                                 input logic [2:0] flush);
        vec_t v;
        v.name = name; v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E;
        v.rdE = rdE; v.rdM = rdM; v.rdW = rdW; v.rwE = rwE; v.rwM = rwM; v.rwW = rwW;
        v.wbsel = wbsel; v.pcsel = pcsel; v.req = req; v.rdy = rdy;
        v.fa = fa; v.fb = fb; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hz.rs1D = v.rs1D; hz.rs2D = v.rs2D; hz.rs1E = v.rs1E; hz.rs2E = v.rs2E;
        hz.rdE = v.rdE; hz.rdM = v.rdM; hz.rdW = v.rdW;
        hz.regwriteE = v.rwE; hz.regwriteM = v.rwM; hz.regwriteW = v.rwW;
        hz.wbselE = v.wbsel; hz.pcselE = v.pcsel;
        hz.dmem_reqM = v.req; hz.dmem_ready = v.rdy;
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        chk({e.name, ".fwdAE"}, 32'(hz.fwdAE), 32'(e.fa));
        chk({e.name, ".fwdBE"}, 32'(hz.fwdBE), 32'(e.fb));
        chk({e.name, ".stall"}, 32'({hz.stallF, hz.stallD, hz.stallE, hz.stallM}), 32'(e.stall));
        chk({e.name, ".flush"}, 32'({hz.flushD, hz.flushE, hz.flushW}), 32'(e.flush));
        chk({e.name, ".mem_err"}, 32'(hz.mem_err), 32'(e.err));
        chk({e.name, ".stall_cnt"}, hz.stall_cnt, e.sc);
        chk({e.name, ".flush_cnt"}, hz.flush_cnt, e.fc);
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance
    // the counter model at the next posedge.
    task automatic cyc(input vec_t v, input logic err_exp);
        exp_t e;
        drive(v);
        e.name = v.name; e.fa = v.fa; e.fb = v.fb; e.stall = v.stall;
        e.flush = v.flush; e.err = err_exp; e.sc = sc_m; e.fc = fc_m;
        sb.push_back(e);
        @(negedge clk);
        sb_check();
        @(posedge clk);
        if (v.stall[3]) sc_m = sc_m + 32'd1;
        if (v.flush[2]) fc_m = fc_m + 32'd1;
        #1;
    endtask

    vec_t tbl[13];
    vec_t v;
    logic [31:0] sc_before;

    initial begin
        //             name         rs1D rs2D rs1E rs2E rdE rdM rdW rwE rwM rwW wb   pc req rdy fa     fb     stall    flush
        tbl[0]  = mkv("fwd_m",      0,   0,   5,   0,   0,  5,  5,  0,  1,  1,  2'b01, 0, 0, 1, 2'b10, 2'b00, 4'b0000, 3'b000);
        tbl[1]  = mkv("fwd_w",      0,   0,   5,   0,   0,  0,  5,  0,  1,  1,  2'b01, 0, 0, 1, 2'b01, 2'b00, 4'b0000, 3'b000);
        tbl[2]  = mkv("fwd_b_w",    0,   0,   5,   5,   0,  0,  5,  0,  1,  1,  2'b01, 0, 0, 1, 2'b01, 2'b01, 4'b0000, 3'b000);
        tbl[3]  = mkv("fwd_none",   0,   0,   5,   5,   0,  0,  0,  0,  1,  1,  2'b01, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[4]  = mkv("fwd_rwm0",   0,   0,   3,   0,   0,  3,  3,  0,  0,  1,  2'b01, 0, 0, 1, 2'b01, 2'b00, 4'b0000, 3'b000);
        tbl[5]  = mkv("fwd_both_m", 0,   0,   9,   9,   0,  9,  9,  0,  1,  1,  2'b01, 0, 0, 1, 2'b10, 2'b10, 4'b0000, 3'b000);
        tbl[6]  = mkv("lu_rs2",     0,   7,   0,   0,   7,  0,  0,  1,  0,  0,  2'b00, 0, 0, 1, 2'b00, 2'b00, 4'b1100, 3'b010);
        tbl[7]  = mkv("lu_rs1",     7,   0,   0,   0,   7,  0,  0,  1,  0,  0,  2'b00, 0, 0, 1, 2'b00, 2'b00, 4'b1100, 3'b010);
        tbl[8]  = mkv("no_lu_alu",  0,   7,   0,   0,   7,  0,  0,  1,  0,  0,  2'b01, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[9]  = mkv("no_lu_x0",   0,   0,   0,   0,   0,  0,  0,  1,  0,  0,  2'b00, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[10] = mkv("redir_lu",   0,   7,   0,   0,   7,  0,  0,  1,  0,  0,  2'b00, 1, 0, 1, 2'b00, 2'b00, 4'b0000, 3'b110);
        tbl[11] = mkv("redir",      0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  2'b01, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110);
        tbl[12] = mkv("idle_req",   0,   0,   0,   0,   0,  0,  0,  0,  0,  0,  2'b01, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b000);

        drive(mkv("rst", 0,0,0,0,0,0,0, 0,0,0, 2'b01, 0,0,1, 2'b00,2'b00,4'b0000,3'b000));
        #2;
        chk("reset.mem_err", 32'(hz.mem_err), 32'd0);
        chk("reset.stall_cnt", hz.stall_cnt, 32'd0);
        chk("reset.flush_cnt", hz.flush_cnt, 32'd0);
        chk("reset.stall", 32'({hz.stallF, hz.stallD, hz.stallE, hz.stallM}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) cyc(tbl[i], 1'b0);
        chk("seq.stall_cnt_after_table", hz.stall_cnt, 32'd2);
        chk("seq.flush_cnt_after_table", hz.flush_cnt, 32'd2);

        // Memory wait of 3 cycles; redirect and load-use present but ignored.
        sc_before = hz.stall_cnt;
        for (int k = 0; k < 3; k++) begin
            v = tbl[10];
            v.name = "mwait"; v.req = 1'b1; v.rdy = 1'b0;
            v.stall = 4'b1111; v.flush = 3'b001;
            cyc(v, 1'b0);
        end
        v = tbl[12]; v.name = "mwait_rel";
        cyc(v, 1'b0);
        chk("mwait.stall_delta", hz.stall_cnt - sc_before, 32'd3);

        // Back-to-back: ready then immediately not ready; wait_cnt must restart
        // or the second 3-cycle wait would reach the timeout of 4.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                v = tbl[12]; v.name = "b2b_wait"; v.rdy = 1'b0;
                v.stall = 4'b1111; v.flush = 3'b001;
                cyc(v, 1'b0);
            end
            v = tbl[12]; v.name = "b2b_rel";
            cyc(v, 1'b0);
        end

        // Timeout: 4 consecutive stall cycles -> ERR on the following edge.
        for (int k = 0; k < 4; k++) begin
            v = tbl[12]; v.name = "tmo_wait"; v.rdy = 1'b0;
            v.stall = 4'b1111; v.flush = 3'b001;
            cyc(v, 1'b0);
        end
        v = tbl[5]; v.name = "err_ready"; v.req = 1'b1; v.rdy = 1'b1; v.pcsel = 1'b1;
        v.stall = 4'b1111; v.flush = 3'b001;
        cyc(v, 1'b1);
        v = tbl[0]; v.name = "err_idle"; v.stall = 4'b1111; v.flush = 3'b001;
        cyc(v, 1'b1);

        // Reset while in ERR: immediate return to RUN with counters cleared.
        v = tbl[12];
        drive(v);
        rst_n = 1'b0;
        #1;
        chk("rst_err.mem_err", 32'(hz.mem_err), 32'd0);
        chk("rst_err.stall_cnt", hz.stall_cnt, 32'd0);
        chk("rst_err.flush_cnt", hz.flush_cnt, 32'd0);
        chk("rst_err.stall", 32'({hz.stallF, hz.stallD, hz.stallE, hz.stallM}), 32'd0);
        sc_m = 32'd0;
        fc_m = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = tbl[12]; v.name = "post_rst";
        cyc(v, 1'b0);
        v = tbl[11]; v.name = "post_rst_redir";
        cyc(v, 1'b0);
        v = tbl[9]; v.name = "post_rst_idle";
        cyc(v, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall/flush controller for the 5-stage RV32 pipeline.
- Each cycle it decides forwarding selects for the Execute operands, load-use stalls, and branch/jump redirect flushes. These drive the `flushE` input of the decode stage and the equivalent controls of the other pipeline registers.
- A registered state machine freezes the whole pipeline while a data-memory access in Memory is not ready. It declares a sticky error if the wait exceeds a timeout.
- Two free-running performance counters record stall cycles and redirect flushes.

## Interface
- MEM_TIMEOUT, 16: consecutive memory-wait stall cycles tolerated before entering ERR (range 2..65535).
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1D, rs2D  input  5  source register fields of the instruction in Decode.
- rs1E, rs2E, rdE  input  5  source and destination fields of the instruction in Execute.
- rdM, rdW  input  5  destination fields in Memory and Writeback.
- regwriteE, regwriteM, regwriteW  input  1  register-write enables per stage.
- wbselE  input  2  writeback select in Execute; 2'b00 identifies a load.
- pcselE  input  1  branch taken or jump resolved in Execute.
- dmem_reqM  input  1  the instruction in Memory performs a data-memory access.
- dmem_ready  input  1  data memory completes the access this cycle.
- stallF, stallD, stallE, stallM  output  1  hold the PC / pipeline register of that stage.
- flushD, flushE, flushW  output  1  load a bubble into the D / E / W pipeline register.
- fwdAE, fwdBE  output  2  operand select for Execute: 00 register file, 01 result from W, 10 ALU result from M.
- mem_err  output  1  sticky memory-timeout error.
- stall_cnt  output  32  number of cycles with stallF=1.
- flush_cnt  output  32  number of cycles with a redirect flush.

## Operation
- Forwarding (combinational, always computed, including in ERR):
  - fwdAE=10 if regwriteM && rdM!=0 && rdM==rs1E.
  - else fwdAE=01 if regwriteW && rdW!=0 && rdW==rs1E.
  - else fwdAE=00.
  - fwdBE is identical using rs2E.
- load_use = regwriteE && wbselE==00 && rdE!=0 && (rdE==rs1D || rdE==rs2D).
  - Conservative by design: rs2D is compared even for I-type instructions.
- mem_stall = dmem_reqM && !dmem_ready, evaluated in RUN or WAIT.
- Priority, highest first:
  1. ERR: stallF=stallD=stallE=stallM=1, flushW=1, all other flushes 0.
  2. mem_stall: stallF..stallM=1, flushW=1, flushD=flushE=0. pcselE and load_use are ignored because the pipeline is frozen.
  3. pcselE: flushD=1, flushE=1, no stalls. Redirect overrides load_use.
  4. load_use: stallF=1, stallD=1, flushE=1.
  5. Otherwise all stall/flush outputs are 0.
- FSM states RUN, WAIT, ERR, with a 16-bit wait_cnt:
  - RUN: if mem_stall, go to WAIT with wait_cnt=1; otherwise stay in RUN.
  - WAIT:
    - if !mem_stall, go to RUN with wait_cnt=0;
    - else if wait_cnt==MEM_TIMEOUT-1, go to ERR;
    - else wait_cnt+1.
  - ERR: terminal until reset. mem_err=1 while in ERR.
- Counters:
  - stall_cnt increments on every cycle with stallF=1, including ERR.
  - flush_cnt increments on every cycle where case 3 is active.
  - Both counters wrap modulo 2^32 with no saturation.

## Timing
- All stall, flush and forward outputs are combinational from inputs and current state, so they act in the same cycle.
- State, wait_cnt and counters are registered and update on the rising clk edge.
- Reset (asynchronous on rst_n low): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
  - Combinational outputs follow the inputs under RUN rules during reset.
  - Reset mid-WAIT or in ERR returns to RUN immediately.
- Memory release takes zero cycles: on the cycle dmem_ready rises, mem_stall=0 and the pipeline advances.
- A stall lasting N cycles with N<MEM_TIMEOUT never enters ERR.
- The MEM_TIMEOUT-th consecutive stall cycle moves the FSM to ERR on the following edge, and mem_err rises on that edge.
- Back-to-back memory accesses:
  - When ready is followed by a new not-ready access in the next cycle, the FSM passes WAIT→RUN→WAIT.
  - wait_cnt restarts at 1 on the new access.

## Test plan
- Forwarding:
  - regwriteM=1, rdM=5, regwriteW=1, rdW=5, rs1E=5 → fwdAE=10.
  - Then set rdM=0 → fwdAE=01.
  - Then set rs2E=5 → fwdBE=01.
  - Set rdW=0 → fwdBE=00.
- Load-use: regwriteE=1, wbselE=00, rdE=7, rs2D=7 → stallF=stallD=flushE=1 for one cycle, and stall_cnt goes 0→1.
- Redirect vs load-use: apply pcselE=1 in the same cycle as a load-use condition → flushD=flushE=1, stallF=0, and flush_cnt increments by 1.
- Memory wait:
  - dmem_reqM=1 with dmem_ready low for 3 cycles, then high → stallF..M=1 and flushW=1 for exactly 3 cycles, then all 0.
  - FSM returns to RUN, mem_err stays 0, and stall_cnt increases by 3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low → mem_err rises after the 4th stall cycle and stalls persist after dmem_ready goes high.
- Reset in ERR: rst_n low → mem_err=0 and both counters read 0 immediately; after release, dmem_ready=1 gives no stall.
